// File: rtl/mm_engine.sv
// Runtime-dimensioned matrix multiplier C = A x B with a 1-cycle-latency operand read port and a backpressured result write port.
// States: IDLE wait start | RDA read A(m,k) | RDB read B(k,n) | MAC accumulate | WR emit C(m,n) | DONE end job.
module mm_engine #(
  parameter int DW   = 20,
  parameter int IW   = 20,
  parameter int ACCW = 48
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [IW-1:0]   dim_m,
  input  logic [IW-1:0]   dim_k,
  input  logic [IW-1:0]   dim_n,
  input  logic            signed_mode,
  input  logic            sat_en,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            ovf,
  output logic            rd_en,
  output logic            rd_sel,
  output logic [IW-1:0]   rd_row,
  output logic [IW-1:0]   rd_col,
  input  logic [DW-1:0]   rd_data,
  output logic            wr_en,
  input  logic            wr_ready,
  output logic [IW-1:0]   wr_row,
  output logic [IW-1:0]   wr_col,
  output logic [ACCW-1:0] wr_data
);

  if (ACCW < 2*DW) begin : g_accw_check
    $error("mm_engine: ACCW must be at least 2*DW");
  end

  localparam int EXTW = ACCW + 1 - 2*DW;
  localparam logic [ACCW-1:0] SMAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] SMIN = {1'b1, {(ACCW-1){1'b0}}};
  localparam logic [ACCW-1:0] UMAX = '1;

  typedef enum logic [2:0] {IDLE, RDA, RDB, MAC, WR, DONE} state_t;

  state_t          state_q;
  logic [IW-1:0]   dim_m_q, dim_k_q, dim_n_q;
  logic [IW-1:0]   m_q, k_q, n_q;
  logic            sgn_q, sat_q;
  logic [DW-1:0]   a_q;
  logic [ACCW:0]   acc_q;
  logic            busy_q, done_q, err_q, ovf_q;
  logic            rd_en_q, rd_sel_q;
  logic [IW-1:0]   rd_row_q, rd_col_q;
  logic            wr_en_q;
  logic [IW-1:0]   wr_row_q, wr_col_q;
  logic [ACCW-1:0] wr_data_q;

  logic [2*DW-1:0] a_x, b_x, prod;
  logic [ACCW:0]   prod_x, sum_d;
  logic            ovf_d;
  logic [ACCW-1:0] res_d;

  // Products are formed at 2*DW bits from sign- or zero-extended operands, so the low half is exact in both modes.
  always_comb begin
    a_x    = {{DW{sgn_q & a_q[DW-1]}}, a_q};
    b_x    = {{DW{sgn_q & rd_data[DW-1]}}, rd_data};
    prod   = a_x * b_x;
    prod_x = {{EXTW{sgn_q & prod[2*DW-1]}}, prod};
    sum_d  = acc_q + prod_x;
    ovf_d  = sgn_q ? (sum_d[ACCW] ^ sum_d[ACCW-1]) : sum_d[ACCW];
    res_d  = sum_d[ACCW-1:0];
    if (ovf_d && sat_q) begin
      if (sgn_q) res_d = sum_d[ACCW] ? SMIN : SMAX;
      else       res_d = UMAX;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      dim_m_q   <= '0;
      dim_k_q   <= '0;
      dim_n_q   <= '0;
      m_q       <= '0;
      k_q       <= '0;
      n_q       <= '0;
      sgn_q     <= 1'b0;
      sat_q     <= 1'b0;
      a_q       <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_row_q  <= '0;
      rd_col_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dim_m_q <= dim_m;
            dim_k_q <= dim_k;
            dim_n_q <= dim_n;
            sgn_q   <= signed_mode;
            sat_q   <= sat_en;
            m_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            if (dim_m == '0 || dim_k == '0 || dim_n == '0) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              err_q    <= 1'b0;
              busy_q   <= 1'b1;
              rd_en_q  <= 1'b1;
              rd_sel_q <= 1'b0;
              rd_row_q <= '0;
              rd_col_q <= '0;
              state_q  <= RDA;
            end
          end
        end
        RDA: begin
          rd_sel_q <= 1'b1;
          rd_row_q <= k_q;
          rd_col_q <= n_q;
          state_q  <= RDB;
        end
        RDB: begin
          a_q     <= rd_data;
          rd_en_q <= 1'b0;
          state_q <= MAC;
        end
        MAC: begin
          acc_q <= sum_d;
          if (k_q == dim_k_q - IW'(1)) begin
            if (ovf_d) ovf_q <= 1'b1;
            wr_en_q   <= 1'b1;
            wr_row_q  <= m_q;
            wr_col_q  <= n_q;
            wr_data_q <= res_d;
            state_q   <= WR;
          end else begin
            k_q      <= k_q + IW'(1);
            rd_en_q  <= 1'b1;
            rd_sel_q <= 1'b0;
            rd_row_q <= m_q;
            rd_col_q <= k_q + IW'(1);
            state_q  <= RDA;
          end
        end
        WR: begin
          // Address and data stay frozen until the sink accepts.
          if (wr_ready) begin
            wr_en_q <= 1'b0;
            acc_q   <= '0;
            k_q     <= '0;
            if (n_q < dim_n_q - IW'(1)) begin
              n_q      <= n_q + IW'(1);
              rd_en_q  <= 1'b1;
              rd_sel_q <= 1'b0;
              rd_row_q <= m_q;
              rd_col_q <= '0;
              state_q  <= RDA;
            end else if (m_q < dim_m_q - IW'(1)) begin
              n_q      <= '0;
              m_q      <= m_q + IW'(1);
              rd_en_q  <= 1'b1;
              rd_sel_q <= 1'b0;
              rd_row_q <= m_q + IW'(1);
              rd_col_q <= '0;
              state_q  <= RDA;
            end else begin
              busy_q  <= 1'b0;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign ovf     = ovf_q;
  assign rd_en   = rd_en_q;
  assign rd_sel  = rd_sel_q;
  assign rd_row  = rd_row_q;
  assign rd_col  = rd_col_q;
  assign wr_en   = wr_en_q;
  assign wr_row  = wr_row_q;
  assign wr_col  = wr_col_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_mm_engine.sv
// Directed bench for mm_engine: a 48-bit instance for function/timing/handshake cases and a 40-bit one for overflow.
module tb_mm_engine;
  localparam int DW = 20;
  localparam int IW = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          start, signed_mode, sat_en, wr_ready;
  logic [IW-1:0] dim_m, dim_k, dim_n;
  logic          busy, done, err, ovf, rd_en, rd_sel, wr_en;
  logic [IW-1:0] rd_row, rd_col, wr_row, wr_col;
  logic [DW-1:0] rd_data = '0;
  logic [47:0]   wr_data;

  logic          start40, signed_mode40, sat_en40, wr_ready40;
  logic [IW-1:0] dim_m40, dim_k40, dim_n40;
  logic          busy40, done40, err40, ovf40, rd_en40, rd_sel40, wr_en40;
  logic [IW-1:0] rd_row40, rd_col40, wr_row40, wr_col40;
  logic [DW-1:0] rd_data40 = '0;
  logic [39:0]   wr_data40;

  mm_engine #(.DW(DW), .IW(IW), .ACCW(48)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .signed_mode(signed_mode), .sat_en(sat_en),
    .busy(busy), .done(done), .err(err), .ovf(ovf),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data)
  );

  mm_engine #(.DW(DW), .IW(IW), .ACCW(40)) u_dut40 (
    .clk(clk), .reset_n(reset_n), .start(start40),
    .dim_m(dim_m40), .dim_k(dim_k40), .dim_n(dim_n40),
    .signed_mode(signed_mode40), .sat_en(sat_en40),
    .busy(busy40), .done(done40), .err(err40), .ovf(ovf40),
    .rd_en(rd_en40), .rd_sel(rd_sel40), .rd_row(rd_row40), .rd_col(rd_col40), .rd_data(rd_data40),
    .wr_en(wr_en40), .wr_ready(wr_ready40), .wr_row(wr_row40), .wr_col(wr_col40), .wr_data(wr_data40)
  );

  logic [DW-1:0] mem_a [4][4];
  logic [DW-1:0] mem_b [4][4];
  logic [DW-1:0] mem_a40 [2][2];
  logic [DW-1:0] mem_b40 [2][2];

  always @(posedge clk) begin
    if (rd_en) rd_data <= rd_sel ? mem_b[rd_row[1:0]][rd_col[1:0]] : mem_a[rd_row[1:0]][rd_col[1:0]];
    if (rd_en40) rd_data40 <= rd_sel40 ? mem_b40[rd_row40[0]][rd_col40[0]] : mem_a40[rd_row40[0]][rd_col40[0]];
  end

  int cyc = 0;
  int both_hi = 0;
  int rd_cnt = 0;
  logic [87:0] wlog[$];
  logic [79:0] last40 = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en && wr_ready) wlog.push_back({wr_row, wr_col, wr_data});
    if (wr_en40 && wr_ready40) last40 <= {wr_row40, wr_col40, wr_data40};
  end

  always @(negedge clk) begin
    if (rd_en && wr_en) both_hi++;
    if (rd_en || wr_en) rd_cnt++;
  end

  int vec = 0;
  int miss = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] outs_vec();
    return 160'({busy, done, err, ovf, rd_en, rd_sel, rd_row, rd_col, wr_en, wr_row, wr_col, wr_data});
  endfunction

  function automatic logic [87:0] get_w(input int i);
    return (i < wlog.size()) ? wlog[i] : '1;
  endfunction

  task automatic load_case1();
    mem_a[0][0] = 20'd1; mem_a[0][1] = 20'd2; mem_a[1][0] = 20'd3; mem_a[1][1] = 20'd4;
    mem_b[0][0] = 20'd5; mem_b[0][1] = 20'd6; mem_b[1][0] = 20'd7; mem_b[1][1] = 20'd8;
  endtask

  task automatic start_job(input int m, input int k, input int n, input bit sgn, input bit sat,
                           output int t0);
    @(negedge clk);
    dim_m = IW'(m); dim_k = IW'(k); dim_n = IW'(n);
    signed_mode = sgn; sat_en = sat; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int t0, input int limit, output int lat);
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_case1(input string pfx);
    check({pfx, "_nwr"}, 160'(wlog.size()), 160'd4);
    check({pfx, "_w00"}, 160'(get_w(0)), 160'({20'd0, 20'd0, 48'd19}));
    check({pfx, "_w01"}, 160'(get_w(1)), 160'({20'd0, 20'd1, 48'd22}));
    check({pfx, "_w10"}, 160'(get_w(2)), 160'({20'd1, 20'd0, 48'd43}));
    check({pfx, "_w11"}, 160'(get_w(3)), 160'({20'd1, 20'd1, 48'd50}));
  endtask

  task automatic run40(input bit sat, output int lat);
    int t0;
    @(negedge clk);
    sat_en40 = sat; start40 = 1'b1;
    @(negedge clk);
    start40 = 1'b0;
    t0 = cyc;
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      if (done40) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d required=finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int t0, lat;
    start = 1'b0; signed_mode = 1'b0; sat_en = 1'b0; wr_ready = 1'b1;
    dim_m = '0; dim_k = '0; dim_n = '0;
    start40 = 1'b0; signed_mode40 = 1'b1; sat_en40 = 1'b0; wr_ready40 = 1'b1;
    dim_m40 = 20'd1; dim_k40 = 20'd2; dim_n40 = 20'd1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mem_a[r][c] = '0;
        mem_b[r][c] = '0;
      end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        mem_a40[r][c] = 20'h80000;
        mem_b40[r][c] = 20'h80000;
      end
    load_case1();

    repeat (2) @(negedge clk);
    check("rst_outs", outs_vec(), '0);
    reset_n = 1'b1;
    @(negedge clk);

    // Case 1: 2x2x2 signed
    wlog.delete();
    start_job(2, 2, 2, 1'b1, 1'b0, t0);
    check("t1_busy", 160'(busy), 160'd1);
    wait_done(t0, 100, lat);
    check("t1_lat", 160'(lat), 160'd29);
    check("t1_flags", 160'({busy, err, ovf}), 160'd0);
    check_case1("t1");

    // Case 2: 1x1x1, 0xFFFFF * 5 in both modes
    mem_a[0][0] = 20'hFFFFF;
    mem_b[0][0] = 20'd5;
    wlog.delete();
    start_job(1, 1, 1, 1'b1, 1'b0, t0);
    wait_done(t0, 50, lat);
    check("t2s_lat", 160'(lat), 160'd5);
    check("t2s_w", 160'(get_w(0)), 160'({20'd0, 20'd0, 48'hFFFF_FFFF_FFFB}));
    wlog.delete();
    start_job(1, 1, 1, 1'b0, 1'b0, t0);
    wait_done(t0, 50, lat);
    check("t2u_w", 160'(get_w(0)), 160'({20'd0, 20'd0, 48'h0000_004F_FFFB}));
    check("t2u_ovf", 160'(ovf), 160'd0);
    load_case1();

    // Case 3: ACCW=40 overflow, saturating and wrapping
    run40(1'b1, lat);
    check("t3s_lat", 160'(lat), 160'd8);
    check("t3s_w", 160'(last40), 160'({20'd0, 20'd0, 40'h7F_FFFF_FFFF}));
    check("t3s_ovf", 160'({ovf40, err40}), 160'b10);
    run40(1'b0, lat);
    check("t3w_w", 160'(last40), 160'({20'd0, 20'd0, 40'h80_0000_0000}));
    check("t3w_ovf", 160'({ovf40, err40}), 160'b10);

    // Case 4: first write stalled 3 cycles
    wlog.delete();
    wr_ready = 1'b0;
    start_job(2, 2, 2, 1'b1, 1'b0, t0);
    for (int i = 0; i < 50 && !wr_en; i++) @(negedge clk);
    check("t4_wr_at", 160'(cyc - t0), 160'd6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t4_hold%0d", i), 160'({wr_en, wr_row, wr_col, wr_data}),
            160'({1'b1, 20'd0, 20'd0, 48'd19}));
    end
    check("t4_nowr", 160'(wlog.size()), 160'd0);
    wr_ready = 1'b1;
    wait_done(t0, 100, lat);
    check("t4_lat", 160'(lat), 160'd32);
    check_case1("t4");

    // Case 5: zero dimension
    wlog.delete();
    start_job(2, 0, 2, 1'b1, 1'b0, t0);
    rd_cnt = 0;
    wait_done(t0, 20, lat);
    check("t5_lat", 160'(lat), 160'd1);
    check("t5_err", 160'({err, busy}), 160'b10);
    check("t5_noacc", 160'(rd_cnt), 160'd0);
    check("t5_nowr", 160'(wlog.size()), 160'd0);
    start_job(1, 1, 1, 1'b1, 1'b0, t0);
    check("t5_errclr", 160'(err), 160'd0);
    wait_done(t0, 50, lat);
    check("t5_w", 160'(get_w(0)), 160'({20'd0, 20'd0, 48'd5}));

    // Case 6: reset during second element, then clean rerun with stray start
    wlog.delete();
    start_job(2, 2, 2, 1'b1, 1'b0, t0);
    repeat (9) @(negedge clk);
    check("t6_pre_nwr", 160'(wlog.size()), 160'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_outs", outs_vec(), '0);
    repeat (2) @(negedge clk);
    check("t6_rst_hold", outs_vec(), '0);
    check("t6_rst_nwr", 160'(wlog.size()), 160'd1);
    reset_n = 1'b1;
    @(negedge clk);
    wlog.delete();
    start_job(2, 2, 2, 1'b1, 1'b0, t0);
    repeat (3) @(negedge clk);
    dim_k = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dim_k = 20'd2;
    wait_done(t0, 100, lat);
    check("t6_lat", 160'(lat), 160'd29);
    check("t6_flags", 160'({err, ovf}), 160'd0);
    check_case1("t6");

    check("rd_wr_excl", 160'(both_hi), 160'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
